// File: rtl/forwarding_hazard_unit.sv
// Scoreboard-based operand forwarding and load-use hazard unit for the MIPS pipeline.
// Bypass selects are resolved at issue from ID and registered, so they are ready when the instruction reaches EX.
module forwarding_hazard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int ADDR_W    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1),
  parameter int CNT_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       freeze_i,
  input  logic                       id_valid_i,
  input  logic                       id_flush_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  id_src_i,
  input  logic [ADDR_W-1:0]          id_dst_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_memread_i,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_o,
  output logic                       hazard_stall_o,
  output logic [CNT_W-1:0]           stall_count_o
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dst;
    logic              regwrite;
    logic              memread;
  } slot_t;

  slot_t [FWD_DEPTH-1:0]      slot_q, slot_d;
  logic [NUM_SRC*SEL_W-1:0]   fwdSel_q, fwdSel_d;
  logic [CNT_W-1:0]           stallCnt_q, stallCnt_d;
  logic                       hazard;
  logic                       issue;

  // Register 0 is hardwired, so a producer targeting it never forwards or stalls.
  function automatic logic slotWrites(input slot_t s, input logic [ADDR_W-1:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != '0);
  endfunction

  // A load is only forwardable once it has reached slot LOAD_LAT-1; any younger load producer stalls ID.
  always_comb begin
    hazard = 1'b0;
    if (id_valid_i && !id_flush_i) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
          if ((k < LOAD_LAT - 1) && slotWrites(slot_q[k], id_src_i[j*ADDR_W +: ADDR_W]) &&
              slot_q[k].memread) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  assign issue = id_valid_i && !id_flush_i && !hazard;

  always_comb begin
    slot_d     = slot_q;
    fwdSel_d   = fwdSel_q;
    stallCnt_d = stallCnt_q;
    if (!freeze_i) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        slot_d[k] = slot_q[k-1];
      end
      slot_d[0] = '0;
      fwdSel_d  = '0;
      if (issue) begin
        slot_d[0].valid    = 1'b1;
        slot_d[0].dst      = id_dst_i;
        slot_d[0].regwrite = id_regwrite_i;
        slot_d[0].memread  = id_memread_i;
        // Scanning oldest to youngest lets the youngest producer overwrite the select.
        for (int j = 0; j < NUM_SRC; j++) begin
          for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (slotWrites(slot_q[k], id_src_i[j*ADDR_W +: ADDR_W])) begin
              fwdSel_d[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
            end
          end
        end
      end
      if (hazard && (stallCnt_q != '1)) begin
        stallCnt_d = stallCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q     <= '0;
      fwdSel_q   <= '0;
      stallCnt_q <= '0;
    end else begin
      slot_q     <= slot_d;
      fwdSel_q   <= fwdSel_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign hazard_stall_o = hazard && rst_ni;
  assign ex_fwd_sel_o   = fwdSel_q;
  assign stall_count_o  = stallCnt_q;

endmodule
